mem_arbiter: RTL and testbench

- Sequences a single shared RAM port among the instruction and data caches of CPUS cores.
- Each cache requester uses a wait/load handshake, the same one a datapath uses toward its caches.
- The arbiter grants one requester at a time with round-robin fairness and holds the grant until the RAM completes.
- It sits between the per-core caches and the RAM model at the top of the multicore system.

---
 rtl/mem_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port among the I/D caches of CPUS cores.
// Optional macro MEM_ARB_DPRIO_EN: dcache requests win over icache requests.
module mem_arbiter #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32,
  parameter int IDW    = $clog2(2*CPUS)
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [CPUS-1:0]        iREN,
  input  logic [WORD_W*CPUS-1:0] iaddr,
  input  logic [CPUS-1:0]        dREN,
  input  logic [CPUS-1:0]        dWEN,
  input  logic [WORD_W*CPUS-1:0] daddr,
  input  logic [WORD_W*CPUS-1:0] dstore,
  output logic [CPUS-1:0]        iwait,
  output logic [CPUS-1:0]        dwait,
  output logic [WORD_W*CPUS-1:0] iload,
  output logic [WORD_W*CPUS-1:0] dload,
  output logic                   ramREN,
  output logic                   ramWEN,
  output logic [WORD_W-1:0]      ramaddr,
  output logic [WORD_W-1:0]      ramstore,
  input  logic [WORD_W-1:0]      ramload,
  input  logic [1:0]             ramstate,
  output logic                   busy,
  output logic [IDW-1:0]         grant_id,
  output logic                   err
);

  localparam int N = 2*CPUS;
  localparam logic [IDW:0] N_W = (IDW+1)'(N);
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [WORD_W-1:0] ERR_WORD = WORD_W'(32'hBAD1BAD1);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  state_t         r_state;
  logic [IDW-1:0] r_rrPtr;
  logic [IDW-1:0] r_grantId;
  logic           r_busy;

  logic [N-1:0]      w_req;
  logic [N-1:0]      w_candidates;
  logic [IDW:0]      w_scanIdx;
  logic [IDW-1:0]    w_winner;
  logic              w_anyReq;
  logic [IDW:0]      w_nextPtrWide;
  logic [IDW-1:0]    w_nextPtr;
  logic              w_gReq;
  logic              w_gRen;
  logic              w_gWen;
  logic [WORD_W-1:0] w_gAddr;
  logic [WORD_W-1:0] w_gStore;
  logic              w_inGrant;
  logic              w_ramDone;
  logic              w_complete;
  logic [WORD_W-1:0] w_loadData;

  // Requester k: even = dcache of core k/2, odd = icache of core k/2.
  always_comb begin
    w_req = '0;
    for (int c = 0; c < CPUS; c++) begin
      w_req[2*c]   = dREN[c] | dWEN[c];
      w_req[2*c+1] = iREN[c];
    end
  end

`ifdef MEM_ARB_DPRIO_EN
  logic w_anyDReq;
  always_comb begin
    w_anyDReq = 1'b0;
    for (int c = 0; c < CPUS; c++) w_anyDReq = w_anyDReq | w_req[2*c];
    for (int c = 0; c < CPUS; c++) begin
      w_candidates[2*c]   = w_req[2*c] & w_anyDReq;
      w_candidates[2*c+1] = w_req[2*c+1] & ~w_anyDReq;
    end
  end
`else
  assign w_candidates = w_req;
`endif

  // First candidate found scanning upward from the round-robin pointer, wrapping at N.
  always_comb begin
    w_anyReq  = 1'b0;
    w_winner  = '0;
    w_scanIdx = '0;
    for (int i = 0; i < N; i++) begin
      w_scanIdx = {1'b0, r_rrPtr} + (IDW+1)'(i);
      if (w_scanIdx >= N_W) w_scanIdx = w_scanIdx - N_W;
      if (!w_anyReq && w_candidates[w_scanIdx[IDW-1:0]]) begin
        w_anyReq = 1'b1;
        w_winner = w_scanIdx[IDW-1:0];
      end
    end
  end

  assign w_nextPtrWide = {1'b0, r_grantId} + (IDW+1)'(1);
  assign w_nextPtr     = (w_nextPtrWide == N_W) ? '0 : w_nextPtrWide[IDW-1:0];

  always_comb begin
    w_gReq   = 1'b0;
    w_gRen   = 1'b0;
    w_gWen   = 1'b0;
    w_gAddr  = '0;
    w_gStore = '0;
    for (int c = 0; c < CPUS; c++) begin
      if (r_grantId == IDW'(2*c)) begin
        w_gReq   = dREN[c] | dWEN[c];
        w_gWen   = dWEN[c];
        w_gRen   = dREN[c] & ~dWEN[c];
        w_gAddr  = daddr[c*WORD_W +: WORD_W];
        w_gStore = dstore[c*WORD_W +: WORD_W];
      end else if (r_grantId == IDW'(2*c+1)) begin
        w_gReq  = iREN[c];
        w_gRen  = iREN[c];
        w_gAddr = iaddr[c*WORD_W +: WORD_W];
      end
    end
  end

  assign w_inGrant  = (r_state == GRANT);
  assign w_ramDone  = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);
  assign w_complete = w_inGrant & w_gReq & w_ramDone;
  assign w_loadData = (ramstate == RAM_ERROR) ? ERR_WORD : ramload;

  assign ramREN   = w_inGrant & w_gRen;
  assign ramWEN   = w_inGrant & w_gWen;
  assign ramaddr  = w_inGrant ? w_gAddr : '0;
  assign ramstore = w_inGrant ? w_gStore : '0;
  assign err      = w_complete & (ramstate == RAM_ERROR);
  assign busy     = r_busy;
  assign grant_id = r_grantId;

  always_comb begin
    iwait = '0;
    dwait = '0;
    iload = '0;
    dload = '0;
    for (int c = 0; c < CPUS; c++) begin
      dwait[c] = w_req[2*c]   & ~(w_complete && r_grantId == IDW'(2*c));
      iwait[c] = w_req[2*c+1] & ~(w_complete && r_grantId == IDW'(2*c+1));
      if (w_complete && r_grantId == IDW'(2*c))   dload[c*WORD_W +: WORD_W] = w_loadData;
      if (w_complete && r_grantId == IDW'(2*c+1)) iload[c*WORD_W +: WORD_W] = w_loadData;
    end
  end

  // A withdrawn request aborts without moving the pointer; completion passes through DONE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= IDLE;
      r_rrPtr   <= '0;
      r_grantId <= '0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_grantId <= w_winner;
            r_busy    <= 1'b1;
            r_state   <= GRANT;
          end
        end
        GRANT: begin
          if (!w_gReq) begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else if (w_ramDone) begin
            r_busy  <= 1'b0;
            r_rrPtr <= w_nextPtr;
            r_state <= DONE;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, grant-order sequences, and random
// traffic compared against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int CPUS = 2;
  localparam int W    = 32;
  localparam int N    = 2*CPUS;
  localparam int IDW  = $clog2(N);

  logic                clk = 1'b0;
  logic                rst;
  logic [CPUS-1:0]     iREN, dREN, dWEN, iwait, dwait;
  logic [W*CPUS-1:0]   iaddr, daddr, dstore, iload, dload;
  logic                ramREN, ramWEN, busy, err;
  logic [W-1:0]        ramaddr, ramstore, ramload;
  logic [1:0]          ramstate;
  logic [IDW-1:0]      grant_id;

  int passCount = 0;
  int checkCount = 0;

  // Reference model: granted requester (-1 when none), bubble flag, pointer, last grant.
  int mGrant;
  int mPtr;
  int mGid;
  bit mBubble;

  int seqGrants[$];
  int seqCycles[$];

  typedef struct {
    logic        rst;
    logic [1:0]  iren, dren, dwen, rstate;
    logic [31:0] rload;
    logic        expBusy;
    logic [1:0]  expGid;
    logic        expRen, expWen;
    logic [31:0] expAddr, expStore;
    logic [1:0]  expIwait, expDwait;
    logic        expErr;
    logic [63:0] expIload, expDload;
  } vector_t;

  vector_t vectors[18];

  mem_arbiter #(.CPUS(CPUS), .WORD_W(W)) dut (
    .CLK(clk), .RST(rst),
    .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate),
    .busy(busy), .grant_id(grant_id), .err(err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setReqs(input logic [N-1:0] mask);
    for (int c = 0; c < CPUS; c++) begin
      dREN[c] = mask[2*c];
      iREN[c] = mask[2*c+1];
    end
    dWEN = '0;
  endtask

  task automatic resetDut();
    rst = 1'b1;
    setReqs('0);
    ramstate = 2'd0;
    ramload = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic applyStimulus(input vector_t v);
    rst      = v.rst;
    iREN     = v.iren;
    dREN     = v.dren;
    dWEN     = v.dwen;
    ramstate = v.rstate;
    ramload  = v.rload;
  endtask

  function automatic logic [N-1:0] currentReqs();
    logic [N-1:0] r;
    for (int c = 0; c < CPUS; c++) begin
      r[2*c]   = dREN[c] | dWEN[c];
      r[2*c+1] = iREN[c];
    end
    return r;
  endfunction

  function automatic int pickWinner(input logic [N-1:0] req, input int ptr);
    bit anyD;
    int k;
    bit eligible;
    anyD = 1'b0;
    for (int c = 0; c < CPUS; c++) anyD |= req[2*c];
    for (int off = 0; off < N; off++) begin
      k = (ptr + off) % N;
      eligible = req[k];
`ifdef MEM_ARB_DPRIO_EN
      eligible = req[k] && ((k % 2 == 0) == anyD);
`endif
      if (eligible) return k;
    end
    return -1;
  endfunction

  task automatic modelCheck(input int cyc);
    logic [N-1:0]    req;
    bit              complete;
    int              core;
    logic            eRen, eWen;
    logic [W-1:0]    eAddr, eStore, loadWord;
    logic [CPUS-1:0] eIw, eDw;
    logic [W*CPUS-1:0] eIl, eDl;
    req = currentReqs();
    complete = 1'b0;
    eRen = 1'b0; eWen = 1'b0; eAddr = '0; eStore = '0;
    eIw = '0; eDw = '0; eIl = '0; eDl = '0;
    if (mGrant >= 0) begin
      core = mGrant / 2;
      if (mGrant % 2 == 0) begin
        eWen   = dWEN[core];
        eRen   = dREN[core] & ~dWEN[core];
        eAddr  = daddr[core*W +: W];
        eStore = dstore[core*W +: W];
      end else begin
        eRen  = iREN[core];
        eAddr = iaddr[core*W +: W];
      end
      complete = req[mGrant] && (ramstate >= 2'd2);
    end
    loadWord = (ramstate == 2'd3) ? 32'hBAD1BAD1 : ramload;
    for (int k = 0; k < N; k++) begin
      bit w;
      w = req[k] && !(complete && k == mGrant);
      if (k % 2 == 0) eDw[k/2] = w;
      else eIw[k/2] = w;
    end
    if (complete) begin
      if (mGrant % 2 == 0) eDl[(mGrant/2)*W +: W] = loadWord;
      else eIl[(mGrant/2)*W +: W] = loadWord;
    end
    checkOutput($sformatf("rnd%0d busy", cyc), busy, (mGrant >= 0));
    checkOutput($sformatf("rnd%0d grant_id", cyc), grant_id, mGid);
    checkOutput($sformatf("rnd%0d ramREN", cyc), ramREN, eRen);
    checkOutput($sformatf("rnd%0d ramWEN", cyc), ramWEN, eWen);
    checkOutput($sformatf("rnd%0d ramaddr", cyc), ramaddr, eAddr);
    if (eWen) checkOutput($sformatf("rnd%0d ramstore", cyc), ramstore, eStore);
    checkOutput($sformatf("rnd%0d iwait", cyc), iwait, eIw);
    checkOutput($sformatf("rnd%0d dwait", cyc), dwait, eDw);
    checkOutput($sformatf("rnd%0d iload", cyc), iload, eIl);
    checkOutput($sformatf("rnd%0d dload", cyc), dload, eDl);
    checkOutput($sformatf("rnd%0d err", cyc), err, complete && ramstate == 2'd3);
  endtask

  task automatic modelStep();
    logic [N-1:0] req;
    int w;
    req = currentReqs();
    if (rst) begin
      mGrant = -1; mBubble = 1'b0; mPtr = 0; mGid = 0;
    end else if (mBubble) begin
      mBubble = 1'b0;
    end else if (mGrant < 0) begin
      w = pickWinner(req, mPtr);
      if (w >= 0) begin
        mGrant = w;
        mGid = w;
      end
    end else if (!req[mGrant]) begin
      mGrant = -1;
    end else if (ramstate >= 2'd2) begin
      mPtr = (mGrant + 1) % N;
      mGrant = -1;
      mBubble = 1'b1;
    end
  endtask

  // Records each completing grant with RAM always ACCESS; optionally retires the winner.
  task automatic runGrantSequence(input logic [N-1:0] startMask, input bit dropOnComplete, input int wantGrants);
    logic [N-1:0] mask;
    int dropIdx;
    mask = startMask;
    dropIdx = -1;
    seqGrants.delete();
    seqCycles.delete();
    resetDut();
    setReqs(mask);
    ramstate = 2'd2;
    for (int cyc = 0; cyc < 60 && seqGrants.size() < wantGrants; cyc++) begin
      @(negedge clk);
      if (busy) begin
        seqGrants.push_back(int'(grant_id));
        seqCycles.push_back(cyc);
        if (dropOnComplete) dropIdx = int'(grant_id);
      end
      tick();
      if (dropIdx >= 0) begin
        mask = mask & ~(N'(1) << dropIdx);
        setReqs(mask);
        dropIdx = -1;
      end
    end
    checkOutput("sequence grant count", seqGrants.size(), wantGrants);
  endtask

  initial begin
    int expFair[5];
    int expPrio[3];
    vector_t v;

    vectors[0]  = '{1'b1, 2'b11, 2'b11, 2'b00, 2'd0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11, 1'b0, 64'h0, 64'h0};
    vectors[1]  = vectors[0];
    vectors[2]  = '{1'b0, 2'b11, 2'b11, 2'b00, 2'd0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b11, 2'b11, 1'b0, 64'h0, 64'h0};
    vectors[3]  = '{1'b0, 2'b11, 2'b11, 2'b00, 2'd1, 32'h0, 1'b1, 2'd0, 1'b1, 1'b0, 32'h200, 32'h0, 2'b11, 2'b11, 1'b0, 64'h0, 64'h0};
    vectors[4]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'd1, 32'h0, 1'b1, 2'd0, 1'b0, 1'b0, 32'h200, 32'h0, 2'b00, 2'b00, 1'b0, 64'h0, 64'h0};
    vectors[5]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'd0, 32'h0, 1'b0, 2'd0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b01, 2'b00, 1'b0, 64'h0, 64'h0};
    vectors[6]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'd1, 32'h0, 1'b1, 2'd1, 1'b1, 1'b0, 32'h40, 32'h0, 2'b01, 2'b00, 1'b0, 64'h0, 64'h0};
    vectors[7]  = vectors[6];
    vectors[8]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'd2, 32'h8C010004, 1'b1, 2'd1, 1'b1, 1'b0, 32'h40, 32'h0, 2'b00, 2'b00, 1'b0, 64'h8C010004, 64'h0};
    vectors[9]  = '{1'b0, 2'b01, 2'b00, 2'b00, 2'd0, 32'h0, 1'b0, 2'd1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b01, 2'b00, 1'b0, 64'h0, 64'h0};
    vectors[10] = '{1'b0, 2'b00, 2'b00, 2'b10, 2'd0, 32'h0, 1'b0, 2'd1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b10, 1'b0, 64'h0, 64'h0};
    vectors[11] = '{1'b0, 2'b00, 2'b00, 2'b10, 2'd1, 32'h0, 1'b1, 2'd2, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 2'b00, 2'b10, 1'b0, 64'h0, 64'h0};
    vectors[12] = '{1'b0, 2'b00, 2'b00, 2'b10, 2'd2, 32'h0, 1'b1, 2'd2, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 2'b00, 2'b00, 1'b0, 64'h0, 64'h0};
    vectors[13] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 64'h0, 64'h0};
    vectors[14] = '{1'b0, 2'b00, 2'b10, 2'b00, 2'd0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b10, 1'b0, 64'h0, 64'h0};
    vectors[15] = '{1'b0, 2'b00, 2'b10, 2'b00, 2'd3, 32'h55, 1'b1, 2'd2, 1'b1, 1'b0, 32'h100, 32'h0, 2'b00, 2'b00, 1'b1, 64'h0, 64'hBAD1BAD1_00000000};
    vectors[16] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'd0, 32'h0, 1'b0, 2'd2, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 64'h0, 64'h0};
    vectors[17] = vectors[16];

`ifdef MEM_ARB_DPRIO_EN
    expFair = '{0, 2, 0, 2, 0};
    expPrio = '{2, 3, 1};
`else
    expFair = '{0, 1, 2, 3, 0};
    expPrio = '{1, 2, 3};
`endif

    iaddr  = {32'h80, 32'h40};
    daddr  = {32'h100, 32'h200};
    dstore = {32'hDEADBEEF, 32'h12345678};
    resetDut();
    rst = 1'b1;

    $display("[TB] directed vector table");
    for (int i = 0; i < 18; i++) begin
      v = vectors[i];
      applyStimulus(v);
      @(negedge clk);
      checkOutput($sformatf("vec%0d busy", i), busy, v.expBusy);
      checkOutput($sformatf("vec%0d grant_id", i), grant_id, v.expGid);
      checkOutput($sformatf("vec%0d ramREN", i), ramREN, v.expRen);
      checkOutput($sformatf("vec%0d ramWEN", i), ramWEN, v.expWen);
      checkOutput($sformatf("vec%0d ramaddr", i), ramaddr, v.expAddr);
      if (v.expWen) checkOutput($sformatf("vec%0d ramstore", i), ramstore, v.expStore);
      checkOutput($sformatf("vec%0d iwait", i), iwait, v.expIwait);
      checkOutput($sformatf("vec%0d dwait", i), dwait, v.expDwait);
      checkOutput($sformatf("vec%0d err", i), err, v.expErr);
      checkOutput($sformatf("vec%0d iload", i), iload, v.expIload);
      checkOutput($sformatf("vec%0d dload", i), dload, v.expDload);
      tick();
    end

    $display("[TB] fairness with all requesters active");
    runGrantSequence(4'b1111, 1'b0, 5);
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("fair grant %0d", i), (i < seqGrants.size()) ? seqGrants[i] : -1, expFair[i]);
    for (int i = 1; i < seqCycles.size(); i++)
      checkOutput($sformatf("fair gap %0d", i), seqCycles[i] - seqCycles[i-1], 3);

    $display("[TB] priority order with requesters 1,2,3");
    runGrantSequence(4'b1110, 1'b1, 3);
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("prio grant %0d", i), (i < seqGrants.size()) ? seqGrants[i] : -1, expPrio[i]);

    $display("[TB] withdrawal mid-transaction");
    resetDut();
    setReqs(4'b0001);
    ramstate = 2'd2;
    tick();
    tick();
    setReqs(4'b1000);
    ramstate = 2'd1;
    tick();
    tick();
    @(negedge clk);
    checkOutput("abort grant_id", grant_id, 3);
    checkOutput("abort busy", busy, 1);
    tick();
    setReqs(4'b0000);
    @(negedge clk);
    checkOutput("abort err", err, 0);
    checkOutput("abort iwait", iwait, 0);
    checkOutput("abort ramREN", ramREN, 0);
    tick();
    @(negedge clk);
    checkOutput("abort idle busy", busy, 0);
    setReqs(4'b0101);
    tick();
    @(negedge clk);
    checkOutput("abort pointer kept", grant_id, 2);
    checkOutput("abort regrant busy", busy, 1);

    $display("[TB] randomized traffic against reference model");
    resetDut();
    mGrant = -1; mBubble = 1'b0; mPtr = 0; mGid = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int c = 0; c < CPUS; c++) begin
        if ($urandom_range(0, 4) == 0) iREN[c] = ~iREN[c];
        if ($urandom_range(0, 4) == 0) dREN[c] = ~dREN[c];
        if ($urandom_range(0, 5) == 0) dWEN[c] = ~dWEN[c];
        iaddr[c*W +: W]  = $urandom;
        daddr[c*W +: W]  = $urandom;
        dstore[c*W +: W] = $urandom;
      end
      ramstate = 2'($urandom_range(0, 3));
      ramload  = $urandom;
      rst      = ($urandom_range(0, 99) == 0);
      @(negedge clk);
      modelCheck(cyc);
      modelStep();
      tick();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
